rv32_lsu: RTL and testbench
===========================

Name: rv32_lsu

Overview:
- Load/store unit in the MEM stage of the 5-stage RV32 pipeline, directly upstream of the word-addressed 32-bit data memory.
- Converts one pipeline load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into memory enable/read/address/data sequences.
- Sub-word stores are done as read-modify-write; load data is byte/halfword extracted and sign/zero extended.
- Misaligned and illegal requests are rejected with an error response and never touch memory.

Parameters:
ADDR_W, 8, word-index width driven to memory (256 words)
MEM_RD_LAT, 2, cycles mem_enable/mem_read/mem_addr must be held before mem_rdata is valid in the following cycle (min 1)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  LSU can accept; high only in IDLE
req_store  input  1  1=store, 0=load
req_funct3  input  3  RV32 funct3 (size/sign)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores/errors
resp_err  output  1  misaligned or illegal funct3
mem_enable  output  1  memory enable
mem_read  output  1  1=read, 0=write (memory writes on every edge where this is 0)
mem_addr  output  32  word index, zero-extended from addr[ADDR_W+1:2]
mem_wdata  output  32  full write word
mem_rdata  input  32  memory read data

Behaviour:
- States: IDLE, RD, CAP, WR, RESP. One request in flight; no pipelining.
- Reset (sampled high): state=IDLE; req_ready=0 during reset, 1 in the first cycle after; resp_valid=0, resp_rdata=0, resp_err=0, mem_enable=0, mem_read=1, mem_addr=0, mem_wdata=0.
- rst high also forces mem_read=1 and mem_enable=0 combinationally in that same cycle, so an in-flight WR is aborted and never written.
- mem_read=1 in every state except WR. No spurious writes, ever.
- Acceptance: req_valid && req_ready at an edge. Latch store, funct3, addr, wdata.
- Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Any other funct3 gives err.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0, gives err.
- Err path: IDLE→RESP; resp_err=1, resp_rdata=0; mem_enable stays 0.
- Load path: IDLE→RD (MEM_RD_LAT cycles; mem_enable=1, mem_read=1, mem_addr held) → CAP (enable/addr still held; sample mem_rdata) → RESP.
- Load latency: resp_valid in cycle MEM_RD_LAT+2 after the accept edge (4 with default).
- Load extraction: byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend bit 7/15 of the lane.
  - LBU/LHU zero-extend.
  - LW passes through.
- SW: IDLE→WR (1 cycle; mem_enable=1, mem_read=0, mem_wdata=wdata) → RESP. resp_valid in cycle 2.
- SB/SH: IDLE→RD→CAP (merge wdata[7:0]/[15:0] into the sampled word at the lane) → WR (merged word) → RESP. resp_valid in cycle MEM_RD_LAT+3 (5 with default).
- RESP: resp_valid=1 for exactly one cycle; state returns to IDLE. Outputs clear to 0 the next cycle; req_ready=0 in RESP.
- Back-to-back: next accept is possible on the edge ending the cycle after RESP.
- Address wrap: bits above ADDR_W+1 are ignored; 0x00000400 maps to word 0.
- req_valid held while req_ready=0 is ignored; no request is dropped or double-accepted.
- mem_addr/mem_wdata change only on state entry. They are held stable through RD/CAP/WR.

Test Plan:
- Reset: assert rst 2 cycles mid-SW (during WR) → memory word unchanged; all outputs at reset values; req_ready=1 first cycle after rst drops.
- Word 3 preloaded 0x80FF7F09; LW 0x0C, LB 0x0F, LBU 0x0F, LH 0x0E, LHU 0x0C → 0x80FF7F09, 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x00007F09. Each resp_valid at cycle 4.
- SB 0x0D data 0x000000AA on word 3 = 0x80FF7F09 → word becomes 0x80FFAA09; single mem_read=0 cycle at cycle 4; resp cycle 5, err=0.
- SW 0x10 data 0xDEADBEEF then LW 0x10 → write in cycle 1, resp at 2; load returns 0xDEADBEEF.
- LH 0x11 and LW 0x0E → resp_err=1 at cycle 1, resp_rdata=0, mem_enable never asserted. funct3=011 load → err.
- SW 0x400 data 0x12345678 then LW 0x0 → 0x12345678 (wrap). req_valid held continuously across 3 requests → exactly 3 accepts, 3 responses.

Source files
------------

// File: rtl/rv32_lsu.sv
// rv32_lsu: MEM-stage load/store unit for a word-addressed 32-bit data memory.
// It handles one request at a time. Sub-word stores are done as read-modify-write.
// Misaligned requests and illegal funct3 values get an error response and never
// touch memory.
module rv32_lsu #(
    parameter int ADDR_W     = 8,
    parameter int MEM_RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_enable,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    localparam logic [7:0] RD_LAST = 8'(MEM_RD_LAT - 1);

    state_t      state_q;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt_q;
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        mem_en_q, mem_rd_q;
    logic [31:0] mem_addr_q, mem_wdata_q;

    // Address bits above the memory's word index are ignored by design, so
    // the address wraps every 4 << ADDR_W bytes.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Returns 1 when the request is misaligned or its funct3 is illegal.
    function automatic logic bad_req(input logic st, input logic [2:0] f3, input logic [1:0] lo);
        logic illegal, misal;
        if (st) illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else    illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                            f3 == 3'b100 || f3 == 3'b101);
        misal = (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
        return illegal || misal;
    endfunction

    // Selects the byte or halfword lane from the memory word and extends it.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Writes the store data into its lane of the word that was read back.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] r;
        r = w;
        if (f3[1:0] == 2'b00)  r[{lo, 3'b000} +: 8] = wd[7:0];
        else if (lo[1])        r[31:16] = wd[15:0];
        else                   r[15:0]  = wd[15:0];
        return r;
    endfunction

    // Reset overrides the registered controls at once, so a write that is in
    // flight is dropped rather than committed.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign mem_enable = mem_en_q && !rst;
    assign mem_read   = mem_rd_q || rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    // Request sequencer. Every output is registered and is updated when the
    // FSM enters a new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            f3_q         <= 3'd0;
            lane_q       <= 2'd0;
            wdata_q      <= 32'd0;
            cnt_q        <= 8'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_rd_q     <= 1'b1;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    store_q <= req_store;
                    f3_q    <= req_funct3;
                    lane_q  <= req_addr[1:0];
                    wdata_q <= req_wdata;
                    if (bad_req(req_store, req_funct3, req_addr[1:0])) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'd0;
                    end else begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
                        if (req_store && req_funct3 == 3'b010) begin
                            state_q     <= WR;
                            mem_rd_q    <= 1'b0;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q  <= RD;
                            mem_rd_q <= 1'b1;
                            cnt_q    <= 8'd0;
                        end
                    end
                end
                RD: begin
                    if (cnt_q == RD_LAST) state_q <= CAP;
                    else                  cnt_q   <= cnt_q + 8'd1;
                end
                CAP: begin
                    if (store_q) begin
                        state_q     <= WR;
                        mem_rd_q    <= 1'b0;
                        mem_wdata_q <= merge(mem_rdata, wdata_q, f3_q, lane_q);
                    end else begin
                        state_q      <= RESP;
                        mem_en_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= extract(mem_rdata, f3_q, lane_q);
                    end
                end
                WR: begin
                    state_q      <= RESP;
                    mem_en_q     <= 1'b0;
                    mem_rd_q     <= 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_lsu.sv
// tb_rv32_lsu: bench for rv32_lsu. It drives directed requests and then random
// ones, and checks the responses against a word-array reference model of the
// load/store rules.
module tb_rv32_lsu;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, mem_enable, mem_read;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0, bad = 0;
    int acc_cnt = 0, rsp_cnt = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int rcnt = 0;

    rv32_lsu #(.ADDR_W(8), .MEM_RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_enable(mem_enable), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model. Read data is valid only after the address has been held
    // with a read enable for LAT cycles. A write happens on every edge where
    // mem_read is low.
    assign mem_rdata = (rcnt >= LAT) ? mem[mem_addr[7:0]] : 32'hBAD0BAD0;
    always @(posedge clk) begin
        if (!mem_read) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_enable && mem_read) rcnt <= rcnt + 1;
        else                        rcnt <= 0;
    end

    // Handshake monitor: counts accepts and response pulses.
    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) acc_cnt++;
        if (resp_valid) rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = (f3 == 3'b010) ? 4 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 1;
        if (st  && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b1;
        if (!st && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        case (f3)
            3'b000: begin v = (w >> (8 * (a % 4))) & 32'hFF;    if (v >= 128)   v = v - 256;   end
            3'b100:       v = (w >> (8 * (a % 4))) & 32'hFF;
            3'b001: begin v = (w >> (8 * (a % 4))) & 32'hFFFF;  if (v >= 32768) v = v - 65536; end
            3'b101:       v = (w >> (8 * (a % 4))) & 32'hFFFF;
            default:      v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] m;
        if (f3 == 3'b010) return wd;
        m = ((f3 == 3'b000) ? 32'hFF : 32'hFFFF) << (8 * (a % 4));
        return (w & ~m) | ((wd << (8 * (a % 4))) & m);
    endfunction

    // Issues one request from an idle cycle, follows it to its response, and
    // checks latency, data, memory traffic and the resulting memory word.
    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic e;
        int lat, k, nwr, nen, wcyc, widx;
        logic [31:0] old, exp_rd, exp_word;
        widx = (a / 4) % 256;
        old  = ref_mem[widx];
        e    = model_err(st, f3, a);
        lat  = e ? 1 : (st && f3 == 3'b010) ? 2 : st ? LAT + 3 : LAT + 2;
        exp_rd   = (e || st) ? 32'd0 : model_load(old, f3, a);
        exp_word = (st && !e) ? model_store(old, wd, f3, a) : old;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        nwr = 0; nen = 0; wcyc = 0;
        for (k = 1; k <= 20; k++) begin
            if (k == 1 && !e) chk("mem_addr", mem_addr, 32'(widx));
            if (!mem_read) begin nwr++; wcyc = k; end
            if (mem_enable) nen++;
            if (resp_valid) break;
            @(posedge clk); #1;
        end
        chk("latency", 32'(k), 32'(lat));
        chk("resp_err", {31'd0, resp_err}, {31'd0, e});
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("write_count", 32'(nwr), (st && !e) ? 32'd1 : 32'd0);
        chk("write_cycle", 32'(wcyc), (st && !e) ? 32'(lat - 1) : 32'd0);
        if (e) chk("err_no_enable", 32'(nen), 32'd0);
        @(posedge clk); #1;
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
        ref_mem[widx] = exp_word;
        chk("mem_word", mem[widx], exp_word);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_en", {31'd0, mem_enable}, 32'd0);
        chk("rst_rd", {31'd0, mem_read}, 32'd1);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[3] = 32'h80FF7F09; ref_mem[3] = 32'h80FF7F09;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Loads of every size and sign from word 3.
        txn(1'b0, 3'b010, 32'h0C, 32'd0);
        chk("lw_val", resp_rdata, 32'd0);
        txn(1'b0, 3'b000, 32'h0F, 32'd0);
        txn(1'b0, 3'b100, 32'h0F, 32'd0);
        txn(1'b0, 3'b001, 32'h0E, 32'd0);
        txn(1'b0, 3'b101, 32'h0C, 32'd0);
        chk("lb_model", model_load(32'h80FF7F09, 3'b000, 32'h0F), 32'hFFFFFF80);

        // Sub-word store as read-modify-write, then a full-word store.
        txn(1'b1, 3'b000, 32'h0D, 32'h000000AA);
        chk("sb_word", mem[3], 32'h80FFAA09);
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        txn(1'b0, 3'b010, 32'h10, 32'd0);

        // Error responses.
        txn(1'b0, 3'b001, 32'h11, 32'd0);
        txn(1'b0, 3'b010, 32'h0E, 32'd0);
        txn(1'b0, 3'b011, 32'h0C, 32'd0);
        txn(1'b1, 3'b100, 32'h0C, 32'h55);

        // Address wrap.
        txn(1'b1, 3'b010, 32'h400, 32'h12345678);
        txn(1'b0, 3'b010, 32'h0, 32'd0);
        chk("wrap_word0", mem[0], 32'h12345678);

        // Reset asserted during a word store. The write must not land.
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        chk_reset_outputs();
        rst = 1'b0;
        #1;
        chk("ready_post_abort", {31'd0, req_ready}, 32'd1);
        chk("aborted_write", mem[5], ref_mem[5]);

        // req_valid held high across three requests.
        acc_cnt = 0; rsp_cnt = 0;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0C;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (acc_cnt >= 3) req_valid = 1'b0;
            if (rsp_cnt >= 3 && !req_valid) break;
        end
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("held_accepts", 32'(acc_cnt), 32'd3);
        chk("held_resps", 32'(rsp_cnt), 32'd3);

        // Random requests against the model.
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 2047);
            if ($urandom_range(0, 1) == 1) a = (f3[1:0] == 2'b10) ? (a & ~32'h3) :
                                                 (f3[1:0] == 2'b01) ? (a & ~32'h1) : a;
            txn(1'($urandom_range(0, 1)), f3, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: stops the run if it hangs.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

endmodule
